// File: rtl/pipe_exe_mdu.sv
// ---------------------------------------------------------------------------
// pipe_exe_mdu
//
// Iterative multiply/divide unit for the EXE stage. It owns the architectural
// HI/LO registers and runs MULT/MULTU/DIV/DIVU as a 32-step shift-add or
// restoring shift-subtract. The pipeline keeps running during an operation.
// Only a later MDU instruction stalls, and only until the unit is idle again.
//
// Ports
//   clock       : rising-edge clock
//   resetn      : synchronous active-low reset
//   emdu_op     : E-stage MDU opcode (0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, others none)
//   ea          : rs operand (dividend / multiplicand / MTHI-MTLO data)
//   eb          : rt operand (divisor / multiplier)
//   mdu_stall   : combinational; MDU op presented while the unit is not idle
//   mdu_busy    : unit is in BUSY or FIX
//   mdu_result  : combinational; HI for MFHI, LO for MFLO, else 0
//   hi, lo      : architectural HI/LO registers
// ---------------------------------------------------------------------------
module pipe_exe_mdu #(
    parameter int ITER = 32
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [3:0]  emdu_op,
    input  logic [31:0] ea,
    input  logic [31:0] eb,
    output logic        mdu_stall,
    output logic        mdu_busy,
    output logic [31:0] mdu_result,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [5:0] LAST_COUNT = 6'(ITER - 1);

    logic [1:0]  state_q,   state_d;
    logic [5:0]  count_q,   count_d;
    logic [63:0] work_q,    work_d;     // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [31:0] opnd_q,    opnd_d;     // multiplicand or divisor magnitude
    logic        is_div_q,  is_div_d;
    logic        neg_q,     neg_d;      // negate product / quotient at FIX
    logic        rem_neg_q, rem_neg_d;  // negate remainder at FIX (dividend sign)
    logic [31:0] hi_q,      hi_d;
    logic [31:0] lo_q,      lo_d;

    // ------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------
    logic is_mdu_op;
    logic is_start;
    logic start_signed;
    logic start_div;

    always_comb begin
        is_mdu_op    = (emdu_op >= OP_MULT) && (emdu_op <= OP_MTLO);
        is_start     = (emdu_op >= OP_MULT) && (emdu_op <= OP_DIVU);
        start_signed = (emdu_op == OP_MULT) || (emdu_op == OP_DIV);
        start_div    = (emdu_op == OP_DIV)  || (emdu_op == OP_DIVU);
    end

    // ------------------------------------------------------------------
    // Operand conditioning: magnitudes for signed ops, raw for unsigned
    // ------------------------------------------------------------------
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    always_comb begin
        a_neg = start_signed && ea[31];
        b_neg = start_signed && eb[31];
        a_mag = a_neg ? (32'd0 - ea) : ea;
        b_mag = b_neg ? (32'd0 - eb) : eb;
    end

    // ------------------------------------------------------------------
    // One iteration step of each algorithm
    // ------------------------------------------------------------------
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_part;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [63:0] div_next;

    always_comb begin
        // Shift-add: add the multiplicand into the upper half when the
        // current multiplier LSB is set, then shift the whole word right
        // (the carry becomes the new MSB).
        mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next = {mul_sum, work_q[31:1]};

        // Restoring divide: shift the next dividend bit into the remainder
        // and subtract the divisor if it fits. The shifted remainder may
        // need 33 bits, the result never does.
        div_part = work_q[63:31];
        div_diff = div_part - {1'b0, opnd_q};
        div_ge   = (div_part >= {1'b0, opnd_q});
        div_next = {(div_ge ? div_diff[31:0] : div_part[31:0]), work_q[30:0], div_ge};
    end

    // ------------------------------------------------------------------
    // Final sign correction
    // ------------------------------------------------------------------
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    always_comb begin
        prod_fix = neg_q     ? (64'd0 - work_q)         : work_q;
        quot_fix = neg_q     ? (32'd0 - work_q[31:0])   : work_q[31:0];
        rem_fix  = rem_neg_q ? (32'd0 - work_q[63:32])  : work_q[63:32];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        work_d    = work_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (is_start) begin
                    state_d   = ST_BUSY;
                    count_d   = 6'd0;
                    is_div_d  = start_div;
                    // A zero divisor leaves the quotient at all ones with no
                    // sign fix. The remainder ends up as |ea| and the dividend
                    // sign fix turns it back into ea exactly.
                    neg_d     = (a_neg ^ b_neg) && !(start_div && (eb == 32'd0));
                    rem_neg_d = start_div && a_neg;
                    if (start_div) begin
                        work_d = {32'd0, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        work_d = {32'd0, b_mag};
                        opnd_d = a_mag;
                    end
                end else if (emdu_op == OP_MTHI) begin
                    hi_d = ea;
                end else if (emdu_op == OP_MTLO) begin
                    lo_d = ea;
                end
            end

            ST_BUSY: begin
                work_d  = is_div_q ? div_next : mul_next;
                count_d = count_q + 6'd1;
                if (count_q == LAST_COUNT) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            count_q   <= 6'd0;
            work_q    <= 64'd0;
            opnd_q    <= 32'd0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            work_q    <= work_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        mdu_stall = is_mdu_op && (state_q != ST_IDLE);
        mdu_busy  = (state_q != ST_IDLE);
        hi        = hi_q;
        lo        = lo_q;
        case (emdu_op)
            OP_MFHI: mdu_result = hi_q;
            OP_MFLO: mdu_result = lo_q;
            default: mdu_result = 32'd0;
        endcase
    end

endmodule
